exu_fpu_queue: RTL and testbench

EXU_FPU_QUEUE -- requirements
Module: exu_fpu_queue

---
 rtl/veer_types.sv | 21 ++
 rtl/exu_fpu_req_fifo.sv | 58 +++++
 rtl/exu_fpu_queue.sv | 150 +++++++++++++++
 tb/tb_exu_fpu_queue.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/veer_types.sv
// Shared types for the EXU FPU request queue: request FIFO entry layout and fflags bit positions.
package veer_types;

    localparam int unsigned FPU_WIDTH = 32;
    localparam int unsigned FPU_OP_W  = 16;
    localparam int unsigned FPU_TAG_W = 5;
    localparam int unsigned FFLAGS_W  = 5;

    localparam int unsigned FFLAG_NX = 0;
    localparam int unsigned FFLAG_UF = 1;
    localparam int unsigned FFLAG_OF = 2;
    localparam int unsigned FFLAG_DZ = 3;
    localparam int unsigned FFLAG_NV = 4;

    typedef struct packed {
        logic [FPU_OP_W-1:0]    op;
        logic [3*FPU_WIDTH-1:0] opnd;
        logic [FPU_TAG_W-1:0]   tag;
    } fpu_req_t;

endpackage

// File: rtl/exu_fpu_req_fifo.sv
// Request FIFO for the FPU issue queue; wrap-bit pointers, flush empties it on the next cycle.
module exu_fpu_req_fifo #(
    parameter int unsigned ENTRY_W = 32,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        // Flush catches the read pointer up to the write pointer.
        if (flush) begin
            rd_ptr_d = wr_ptr_d;
        end else if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/exu_fpu_queue.sv
// FPU request queue: buffers requests, limits ops in flight, drops flushed results, registers responses.
// Define RV_FPU_FFLAGS_ACCUM_EN to make rsp_fflags a sticky OR of accepted result flags.
module exu_fpu_queue
    import veer_types::*;
#(
    parameter int unsigned WIDTH     = FPU_WIDTH,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned TAG_W     = FPU_TAG_W,
    parameter int unsigned OP_W      = FPU_OP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_W-1:0]       req_op,
    input  logic [3*WIDTH-1:0]    req_opnd,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  fpu_in_valid,
    input  logic                  fpu_in_ready,
    output logic [OP_W-1:0]       fpu_op,
    output logic [3*WIDTH-1:0]    fpu_opnd,
    output logic [TAG_W-1:0]      fpu_tag,
    input  logic                  fpu_out_valid,
    input  logic [WIDTH-1:0]      fpu_result,
    input  logic [FFLAGS_W-1:0]   fpu_status,
    input  logic [TAG_W-1:0]      fpu_tag_o,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [FFLAGS_W-1:0]   rsp_fflags,
    input  logic                  fflags_clr,
    output logic                  busy
);

    localparam int unsigned OW      = $clog2(MAX_OUTST + 1);
    localparam int unsigned ENTRY_W = $bits(fpu_req_t);

    fpu_req_t            req_entry;
    fpu_req_t            head;
    logic                fifo_full, fifo_empty;
    logic                issue, drop, accept;
    logic [OW-1:0]       outst_q, outst_d;
    logic [OW-1:0]       drain_q, drain_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic [FFLAGS_W-1:0] rsp_fflags_q, rsp_fflags_d;

    // Entry field widths follow the veer_types configuration.
    assign req_entry.op   = req_op;
    assign req_entry.opnd = req_opnd;
    assign req_entry.tag  = req_tag;

    exu_fpu_req_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (req_valid & req_ready),
        .wdata (req_entry),
        .pop   (issue),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_ready    = ~fifo_full & ~flush;
    assign fpu_in_valid = ~fifo_empty & (outst_q < OW'(MAX_OUTST)) & (drain_q == '0) & ~flush;
    assign fpu_op       = head.op;
    assign fpu_opnd     = head.opnd;
    assign fpu_tag      = head.tag;
    assign issue        = fpu_in_valid & fpu_in_ready;
    assign drop         = fpu_out_valid & ((drain_q != '0) | flush);
    assign accept       = fpu_out_valid & ~drop;
    assign busy         = ~fifo_empty | (outst_q != '0);

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_fflags = rsp_fflags_q;

`ifndef RV_FPU_FFLAGS_ACCUM_EN
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr;
`endif

    always_comb begin
        outst_d      = outst_q;
        drain_d      = drain_q;
        rsp_valid_d  = accept;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_fflags_d = rsp_fflags_q;

        // A return with nothing in flight is illegal; the counter holds at zero.
        if (issue && !fpu_out_valid) begin
            outst_d = outst_q + OW'(1);
        end else if (!issue && fpu_out_valid && outst_q != '0) begin
            outst_d = outst_q - OW'(1);
        end

        // Results still owed by the datapath at flush time are discarded on return.
        if (flush) begin
            drain_d = outst_d;
        end else if (fpu_out_valid && drain_q != '0) begin
            drain_d = drain_q - OW'(1);
        end

        if (accept) begin
            rsp_result_d = fpu_result;
            rsp_tag_d    = fpu_tag_o;
        end

`ifdef RV_FPU_FFLAGS_ACCUM_EN
        if (fflags_clr) begin
            rsp_fflags_d = '0;
        end
        if (accept) begin
            rsp_fflags_d = rsp_fflags_d | fpu_status;
        end
`else
        if (accept) begin
            rsp_fflags_d = fpu_status;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_q      <= '0;
            drain_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            rsp_fflags_q <= '0;
        end else begin
            outst_q      <= outst_d;
            drain_q      <= drain_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_fflags_q <= rsp_fflags_d;
        end
    end

endmodule

// File: tb/tb_exu_fpu_queue.sv
// Bench for exu_fpu_queue: directed cycle table plus randomized traffic against a queue-based model.
module tb_exu_fpu_queue;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic [15:0]  req_op;
    logic [95:0]  req_opnd;
    logic [4:0]   req_tag;
    logic         fpu_in_valid;
    logic         fpu_in_ready;
    logic [15:0]  fpu_op;
    logic [95:0]  fpu_opnd;
    logic [4:0]   fpu_tag;
    logic         fpu_out_valid;
    logic [W-1:0] fpu_result;
    logic [4:0]   fpu_status;
    logic [4:0]   fpu_tag_o;
    logic         rsp_valid;
    logic [W-1:0] rsp_result;
    logic [4:0]   rsp_tag;
    logic [4:0]   rsp_fflags;
    logic         fflags_clr;
    logic         busy;

    exu_fpu_queue dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_opnd      (req_opnd),
        .req_tag       (req_tag),
        .fpu_in_valid  (fpu_in_valid),
        .fpu_in_ready  (fpu_in_ready),
        .fpu_op        (fpu_op),
        .fpu_opnd      (fpu_opnd),
        .fpu_tag       (fpu_tag),
        .fpu_out_valid (fpu_out_valid),
        .fpu_result    (fpu_result),
        .fpu_status    (fpu_status),
        .fpu_tag_o     (fpu_tag_o),
        .rsp_valid     (rsp_valid),
        .rsp_result    (rsp_result),
        .rsp_tag       (rsp_tag),
        .rsp_fflags    (rsp_fflags),
        .fflags_clr    (fflags_clr),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Inputs per cycle, then the outputs expected in that same cycle (before the edge).
    typedef struct {
        int rv; int tag; int ir; int ov; int otag; int st; int fl; int clr;
        int e_rr; int e_iv; int e_ft; int e_rv; int e_rt; int e_busy; int e_ffa; int e_ffl;
    } vec_t;

    typedef struct { logic [15:0] op; logic [95:0] opnd; logic [4:0] tag; } req_t;
    typedef struct { req_t r; bit doomed; } fl_t;

    int          checks;
    int          failures;
    vec_t        tbl [27];
    vec_t        v;
    req_t        mq[$];
    fl_t         infl[$];
    fl_t         h;
    req_t        nr;
    bit          pend_rsp;
    logic [31:0] m_res;
    logic [4:0]  m_tag;
    logic [4:0]  m_ff;
    int          n_doomed;
    bit          r_fl, r_rv, r_ir, r_ret, r_clr, accepted;
    bit          exp_rr, exp_iv, exp_busy;
    logic [31:0] r_res;
    logic [4:0]  r_st;
    int unsigned obs_outst;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The FPU must never return a result when nothing was issued to it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            obs_outst <= 0;
        end else begin
            if (fpu_out_valid) assert (obs_outst != 0) else $error("illegal FPU return with nothing in flight");
            obs_outst <= obs_outst + ((fpu_in_valid && fpu_in_ready) ? 1 : 0) - (fpu_out_valid ? 1 : 0);
        end
    end

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_opnd = '0; req_tag = '0;
        fpu_in_ready = 1'b0; fpu_out_valid = 1'b0; fpu_result = '0; fpu_status = '0;
        fpu_tag_o = '0; fflags_clr = 1'b0;

        //          rv tag ir ov otag st fl clr | rr iv ft rv rt busy ffa ffl
        tbl = '{
            '{1, 3, 1,0, 0, 0, 0,0,  1,0, 0,0, 0,0, 0, 0},
            '{0, 0, 1,0, 0, 0, 0,0,  1,1, 3,0, 0,1, 0, 0},
            '{0, 0, 1,0, 0, 0, 0,0,  1,0, 0,0, 0,1, 0, 0},
            '{0, 0, 1,1, 3, 1, 0,0,  1,0, 0,0, 0,1, 0, 0},
            '{0, 0, 0,0, 0, 0, 0,0,  1,0, 0,1, 3,0, 1, 1},
            '{0, 0, 0,0, 0, 0, 0,0,  1,0, 0,0, 3,0, 1, 1},
            '{1,10, 0,0, 0, 0, 0,0,  1,0, 0,0, 3,0, 1, 1},
            '{1,11, 0,0, 0, 0, 0,0,  1,1,10,0, 3,1, 1, 1},
            '{1,12, 0,0, 0, 0, 0,0,  1,1,10,0, 3,1, 1, 1},
            '{1,13, 0,0, 0, 0, 0,0,  1,1,10,0, 3,1, 1, 1},
            '{1,14, 0,0, 0, 0, 0,0,  0,1,10,0, 3,1, 1, 1},
            '{1,14, 0,0, 0, 0, 0,0,  0,1,10,0, 3,1, 1, 1},
            '{1,14, 1,0, 0, 0, 0,0,  0,1,10,0, 3,1, 1, 1},
            '{1,14, 1,0, 0, 0, 0,0,  1,1,11,0, 3,1, 1, 1},
            '{0, 0, 1,0, 0, 0, 0,0,  1,1,12,0, 3,1, 1, 1},
            '{0, 0, 1,0, 0, 0, 0,0,  1,1,13,0, 3,1, 1, 1},
            '{0, 0, 1,0, 0, 0, 0,0,  1,0, 0,0, 3,1, 1, 1},
            '{0, 0, 1,1,10, 8, 0,0,  1,0, 0,0, 3,1, 1, 1},
            '{0, 0, 1,0, 0, 0, 0,0,  1,1,14,1,10,1, 9, 8},
            '{1,15, 0,1,11, 4, 0,0,  1,0, 0,0,10,1, 9, 8},
            '{0, 0, 0,1,12, 2, 1,0,  0,0, 0,1,11,1,13, 4},
            '{1,20, 0,1,13,16, 0,0,  1,0, 0,0,11,1,13, 4},
            '{0, 0, 1,1,14,16, 0,1,  1,0, 0,0,11,1,13, 4},
            '{0, 0, 1,0, 0, 0, 0,0,  1,1,20,0,11,1, 0, 4},
            '{0, 0, 1,0, 0, 0, 0,0,  1,0, 0,0,11,1, 0, 4},
            '{0, 0, 0,1,20, 1, 0,1,  1,0, 0,0,11,1, 0, 4},
            '{0, 0, 0,0, 0, 0, 0,0,  1,0, 0,1,20,0, 1, 1}
        };

        // Reset values, sampled while reset is held.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid",  128'(rsp_valid),    128'(0));
        chk("rst_rsp_result", 128'(rsp_result),   128'(0));
        chk("rst_rsp_tag",    128'(rsp_tag),      128'(0));
        chk("rst_rsp_fflags", 128'(rsp_fflags),   128'(0));
        chk("rst_busy",       128'(busy),         128'(0));
        chk("rst_in_valid",   128'(fpu_in_valid), 128'(0));
        chk("rst_req_ready",  128'(req_ready),    128'(1));
        rst = 1'b0;

        // Directed cycle table.
        for (int i = 0; i < 27; i++) begin
            v = tbl[i];
            req_valid     = 1'(v.rv);
            req_tag       = 5'(v.tag);
            req_op        = 16'(16'hA500 + v.tag);
            req_opnd      = {32'(v.tag), 32'hB0B0_0000, 32'h1234_0000};
            fpu_in_ready  = 1'(v.ir);
            fpu_out_valid = 1'(v.ov);
            fpu_tag_o     = 5'(v.otag);
            fpu_result    = 32'hC0DE_0000 | 32'(v.otag);
            fpu_status    = 5'(v.st);
            flush         = 1'(v.fl);
            fflags_clr    = 1'(v.clr);
            #1;
            chk($sformatf("tbl%0d_req_ready", i), 128'(req_ready),    128'(v.e_rr));
            chk($sformatf("tbl%0d_in_valid", i),  128'(fpu_in_valid), 128'(v.e_iv));
            if (v.e_iv != 0) begin
                chk($sformatf("tbl%0d_fpu_tag", i), 128'(fpu_tag), 128'(v.e_ft));
            end
            chk($sformatf("tbl%0d_rsp_valid", i), 128'(rsp_valid), 128'(v.e_rv));
            chk($sformatf("tbl%0d_rsp_tag", i),   128'(rsp_tag),   128'(v.e_rt));
            chk($sformatf("tbl%0d_rsp_result", i), 128'(rsp_result),
                (v.e_rt == 0) ? 128'(0) : 128'(32'hC0DE_0000 | 32'(v.e_rt)));
            chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(v.e_busy));
`ifdef RV_FPU_FFLAGS_ACCUM_EN
            chk($sformatf("tbl%0d_fflags", i), 128'(rsp_fflags), 128'(v.e_ffa));
`else
            chk($sformatf("tbl%0d_fflags", i), 128'(rsp_fflags), 128'(v.e_ffl));
`endif
            tick();
        end

        // Randomized traffic; the model starts from the table's end state.
        pend_rsp = 1'b0;
        m_res    = 32'hC0DE_0014;
        m_tag    = 5'd20;
        m_ff     = 5'd1 << veer_types::FFLAG_NX;
        for (int i = 0; i < 800; i++) begin
            n_doomed = 0;
            foreach (infl[k]) if (infl[k].doomed) n_doomed++;
            r_fl  = ($urandom_range(0, 19) == 0);
            r_rv  = ($urandom_range(0, 1) == 1);
            r_ir  = ($urandom_range(0, 3) != 0);
            r_ret = (infl.size() != 0) && ($urandom_range(0, 2) == 0);
            r_clr = ($urandom_range(0, 7) == 0);
            r_res = $urandom;
            r_st  = 5'($urandom);
            nr.op   = 16'($urandom);
            nr.opnd = {$urandom, $urandom, $urandom};
            nr.tag  = 5'($urandom);

            req_valid     = r_rv;
            req_op        = nr.op;
            req_opnd      = nr.opnd;
            req_tag       = nr.tag;
            fpu_in_ready  = r_ir;
            flush         = r_fl;
            fflags_clr    = r_clr;
            fpu_out_valid = r_ret;
            fpu_tag_o     = r_ret ? infl[0].r.tag : 5'd0;
            fpu_result    = r_res;
            fpu_status    = r_st;

            exp_rr   = (mq.size() < 4) && !r_fl;
            exp_iv   = (mq.size() != 0) && (infl.size() < 4) && (n_doomed == 0) && !r_fl;
            exp_busy = (mq.size() != 0) || (infl.size() != 0);
            #1;
            chk("rnd_req_ready",  128'(req_ready),    128'(exp_rr));
            chk("rnd_in_valid",   128'(fpu_in_valid), 128'(exp_iv));
            chk("rnd_busy",       128'(busy),         128'(exp_busy));
            if (exp_iv) begin
                chk("rnd_fpu_tag",  128'(fpu_tag),  128'(mq[0].tag));
                chk("rnd_fpu_op",   128'(fpu_op),   128'(mq[0].op));
                chk("rnd_fpu_opnd", 128'(fpu_opnd), 128'(mq[0].opnd));
            end
            chk("rnd_rsp_valid",  128'(rsp_valid),  128'(pend_rsp));
            chk("rnd_rsp_result", 128'(rsp_result), 128'(m_res));
            chk("rnd_rsp_tag",    128'(rsp_tag),    128'(m_tag));
            chk("rnd_rsp_fflags", 128'(rsp_fflags), 128'(m_ff));

            pend_rsp = 1'b0;
            accepted = 1'b0;
            if (r_ret) begin
                h = infl.pop_front();
                accepted = !h.doomed && !r_fl;
                if (accepted) begin
                    pend_rsp = 1'b1;
                    m_res    = r_res;
                    m_tag    = h.r.tag;
                end
            end
`ifdef RV_FPU_FFLAGS_ACCUM_EN
            m_ff = (r_clr ? 5'd0 : m_ff) | (accepted ? r_st : 5'd0);
`else
            if (accepted) m_ff = r_st;
`endif
            if (exp_iv && r_ir) begin
                h.r      = mq.pop_front();
                h.doomed = 1'b0;
                infl.push_back(h);
            end
            if (r_rv && exp_rr) mq.push_back(nr);
            if (r_fl) begin
                mq.delete();
                foreach (infl[k]) infl[k].doomed = 1'b1;
            end
            tick();
        end

        // Reset in the middle of traffic discards everything, FPU included.
        req_valid = 1'b1; fpu_in_ready = 1'b0; fpu_out_valid = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
        tick();
        rst = 1'b1;
        mq.delete();
        infl.delete();
        #1;
        chk("midrst_busy",      128'(busy),         128'(0));
        chk("midrst_in_valid",  128'(fpu_in_valid), 128'(0));
        chk("midrst_rsp_valid", 128'(rsp_valid),    128'(0));
        chk("midrst_req_ready", 128'(req_ready),    128'(1));
        chk("midrst_fflags",    128'(rsp_fflags),   128'(0));
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_busy",     128'(busy),         128'(0));
        chk("postrst_in_valid", 128'(fpu_in_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
